// File: rtl/ev_sched_if.sv
// rtl/ev_sched_if.sv - requester/drive bundle for ev_sched; EV_SCHED_CANCEL_EN adds cancel/cancelled
interface ev_sched_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int CW    = 8
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ*CW-1:0] req_delay;
    logic [N_REQ-1:0]    ack;
    logic                drv_valid;
    logic [DW-1:0]       drv_data;
    logic [IW-1:0]       drv_id;
    logic                busy;
`ifdef EV_SCHED_CANCEL_EN
    logic                cancel;
    logic                cancelled;

    modport master (
        output req, req_data, req_delay, cancel,
        input  ack, drv_valid, drv_data, drv_id, busy, cancelled
    );
    modport slave (
        input  req, req_data, req_delay, cancel,
        output ack, drv_valid, drv_data, drv_id, busy, cancelled
    );
`else
    modport master (
        output req, req_data, req_delay,
        input  ack, drv_valid, drv_data, drv_id, busy
    );
    modport slave (
        input  req, req_data, req_delay,
        output ack, drv_valid, drv_data, drv_id, busy
    );
`endif
endinterface

// File: rtl/ev_sched.sv
// rtl/ev_sched.sv - round-robin delayed event scheduler sharing one drive port; EV_SCHED_CANCEL_EN adds WAIT cancel
module ev_sched #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    ev_sched_if.slave  bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FIRE = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    ptr;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    data_q;
    logic [IW-1:0]    id_q;
    logic [N_REQ-1:0] ack_q;
    logic [DW-1:0]    drv_data_q;
    logic [IW-1:0]    drv_id_q;
    logic             cancel_hit;

    logic             found;
    logic [IW-1:0]    win;
    logic [IW:0]      pos;
    logic [DW-1:0]    sel_data;
    logic [CW-1:0]    sel_delay;
    logic [IW-1:0]    ptr_next;

    // Rotating search from ptr; pos carries one extra bit so non-power-of-two N_REQ wraps correctly
    always_comb begin
        found = 1'b0;
        win   = '0;
        pos   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = {1'b0, ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(N_REQ))
                pos = pos - (IW+1)'(N_REQ);
            if (!found && bus.req[pos[IW-1:0]]) begin
                found = 1'b1;
                win   = pos[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_delay = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IW'(i) == win) begin
                sel_data  = bus.req_data[i*DW +: DW];
                sel_delay = bus.req_delay[i*CW +: CW];
            end
        end
    end

    assign ptr_next = (win == IW'(N_REQ-1)) ? '0 : win + 1'b1;

`ifdef EV_SCHED_CANCEL_EN
    logic cancelled_q;

    assign cancel_hit    = bus.cancel;
    assign bus.cancelled = cancelled_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cancelled_q <= 1'b0;
        else
            cancelled_q <= (state == S_WAIT) && bus.cancel;
    end
`else
    assign cancel_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            data_q     <= '0;
            id_q       <= '0;
            ack_q      <= '0;
            drv_data_q <= '0;
            drv_id_q   <= '0;
        end else begin
            ack_q <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        ack_q  <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                        ptr    <= ptr_next;
                        data_q <= sel_data;
                        id_q   <= win;
                        if (sel_delay == '0) begin
                            // Zero delay fires straight away, so the drive outputs load from the winner now
                            state      <= S_FIRE;
                            drv_data_q <= sel_data;
                            drv_id_q   <= win;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= sel_delay - 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cancel_hit) begin
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        state      <= S_FIRE;
                        drv_data_q <= data_q;
                        drv_id_q   <= id_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FIRE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.drv_valid = (state == S_FIRE);
    assign bus.drv_data  = drv_data_q;
    assign bus.drv_id    = drv_id_q;
    assign bus.busy      = (state != S_IDLE);
endmodule
